// File: rtl/ball_sprite.sv
// Moving square sprite: holds at a serve position, then steps once per frame and bounces off the screen edges.
// Optional BALL_HIT_FLASH_EN: inverts the sprite colour for four frames after every bounce.
module ball_sprite #(
    parameter int         COORD_W      = 11,
    parameter int         SCREEN_W     = 640,
    parameter int         SCREEN_H     = 480,
    parameter int         SIZE         = 8,
    parameter int         SPEED_X      = 2,
    parameter int         SPEED_Y      = 1,
    parameter int         START_X      = 316,
    parameter int         START_Y      = 236,
    parameter int         SERVE_FRAMES = 60,
    parameter logic [1:0] R            = 2'b01,
    parameter logic [1:0] G            = 2'b00,
    parameter logic [1:0] B            = 2'b00
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               frame_tick,
    input  logic               run,
    input  logic               serve,
    output logic               en,
    output logic [1:0]         r,
    output logic [1:0]         g,
    output logic [1:0]         b,
    output logic [COORD_W-1:0] bx,
    output logic [COORD_W-1:0] by,
    output logic               hit_x,
    output logic               hit_y
);

    typedef enum logic {HOLD, RUN} state_t;

    localparam int CNT_W = $clog2(SERVE_FRAMES + 2);

    localparam logic [COORD_W-1:0] MAX_X    = COORD_W'(SCREEN_W - SIZE);
    localparam logic [COORD_W-1:0] MAX_Y    = COORD_W'(SCREEN_H - SIZE);
    localparam logic [COORD_W-1:0] STEP_X   = COORD_W'(SPEED_X);
    localparam logic [COORD_W-1:0] STEP_Y   = COORD_W'(SPEED_Y);
    localparam logic [COORD_W-1:0] SIDE     = COORD_W'(SIZE);
    localparam logic [COORD_W-1:0] HOME_X   = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] HOME_Y   = COORD_W'(START_Y);
    localparam logic [CNT_W-1:0]   SERVE_CNT = CNT_W'(SERVE_FRAMES);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [COORD_W-1:0] bx_n, by_n;
    logic               dir_x, dir_x_n, dir_y, dir_y_n;
    logic               hit_x_n, hit_y_n, en_n;
    logic [COORD_W:0]   step_x, step_y;
    logic               do_step;

    // One axis step: returns {bounced, new_position}; sums are one bit wider so they cannot wrap.
    function automatic logic [COORD_W:0] axis_step(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [COORD_W-1:0] step,
        input logic [COORD_W-1:0] max_pos
    );
        logic [COORD_W:0] res;
        if (dir) begin
            if (({1'b0, pos} + {1'b0, step}) > {1'b0, max_pos}) res = {1'b1, max_pos};
            else                                                 res = {1'b0, pos + step};
        end else begin
            if (pos < step) res = {1'b1, {COORD_W{1'b0}}};
            else            res = {1'b0, pos - step};
        end
        return res;
    endfunction

    assign step_x = axis_step(bx, dir_x, STEP_X, MAX_X);
    assign step_y = axis_step(by, dir_y, STEP_Y, MAX_Y);

    // NOTE: every variable written here gets a default first, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bx_n    = bx;
        by_n    = by;
        dir_x_n = dir_x;
        dir_y_n = dir_y;
        hit_x_n = 1'b0;
        hit_y_n = 1'b0;
        do_step = 1'b0;

        if (serve) begin
            state_n = HOLD;
            cnt_n   = '0;
            bx_n    = HOME_X;
            by_n    = HOME_Y;
            dir_x_n = ~dir_x;
        end else if (frame_tick && run) begin
            case (state)
                HOLD: begin
                    // Only reachable with SERVE_FRAMES == 0: move on the very first tick.
                    if (cnt == SERVE_CNT) begin
                        state_n = RUN;
                        do_step = 1'b1;
                    end else begin
                        cnt_n = cnt + CNT_W'(1);
                        if (cnt_n == SERVE_CNT) state_n = RUN;
                    end
                end
                RUN:     do_step = 1'b1;
                default: state_n = HOLD;
            endcase
        end

        if (do_step) begin
            bx_n    = step_x[COORD_W-1:0];
            by_n    = step_y[COORD_W-1:0];
            dir_x_n = dir_x ^ step_x[COORD_W];
            dir_y_n = dir_y ^ step_y[COORD_W];
            hit_x_n = step_x[COORD_W];
            hit_y_n = step_y[COORD_W];
        end
    end

    assign en_n = (x >= bx) && ({1'b0, x} < ({1'b0, bx} + {1'b0, SIDE})) &&
                  (y >= by) && ({1'b0, y} < ({1'b0, by} + {1'b0, SIDE}));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HOLD;
            cnt   <= '0;
            bx    <= HOME_X;
            by    <= HOME_Y;
            dir_x <= 1'b1;
            dir_y <= 1'b1;
            hit_x <= 1'b0;
            hit_y <= 1'b0;
            en    <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            bx    <= bx_n;
            by    <= by_n;
            dir_x <= dir_x_n;
            dir_y <= dir_y_n;
            hit_x <= hit_x_n;
            hit_y <= hit_y_n;
            en    <= en_n;
        end
    end

`ifdef BALL_HIT_FLASH_EN
    logic [2:0] flash;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          flash <= 3'd0;
        else if (serve)                      flash <= 3'd0;
        else if (hit_x || hit_y)             flash <= 3'd4;
        else if (frame_tick && flash != 3'd0) flash <= flash - 3'd1;
    end

    assign r = (flash != 3'd0) ? ~R : R;
    assign g = (flash != 3'd0) ? ~G : G;
    assign b = (flash != 3'd0) ? ~B : B;
`else
    assign r = R;
    assign g = G;
    assign b = B;
`endif

endmodule

// File: tb/tb_ball_sprite.sv
// Self-checking bench for ball_sprite: randomized frame ticks, run and serve against a frame-level model.
// Start position is chosen so the right and bottom walls are reached on the same tick (corner bounce).
module tb_ball_sprite;

    localparam int         CW  = 11;
    localparam int         SW  = 640;
    localparam int         SH  = 480;
    localparam int         SZ  = 8;
    localparam int         VX  = 2;
    localparam int         VY  = 2;
    localparam int         SX  = 316;
    localparam int         SY  = 156;
    localparam int         SF  = 2;
    localparam logic [1:0] CR  = 2'b01;
    localparam logic [1:0] CG  = 2'b00;
    localparam logic [1:0] CB  = 2'b00;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] x = '0, y = '0;
    logic          frame_tick = 1'b0, run = 1'b0, serve = 1'b0;
    logic          en, hit_x, hit_y;
    logic [1:0]    r, g, b;
    logic [CW-1:0] bx, by;

    int checks = 0;
    int failures = 0;

    // Frame-level model of the ball
    int m_bx, m_by, m_dx, m_dy, m_wait, m_flash;
    bit m_hx, m_hy;

    ball_sprite #(
        .COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH), .SIZE(SZ),
        .SPEED_X(VX), .SPEED_Y(VY), .START_X(SX), .START_Y(SY),
        .SERVE_FRAMES(SF), .R(CR), .G(CG), .B(CB)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y),
        .frame_tick(frame_tick), .run(run), .serve(serve),
        .en(en), .r(r), .g(g), .b(b), .bx(bx), .by(by),
        .hit_x(hit_x), .hit_y(hit_y)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_bx = SX; m_by = SY; m_dx = 1; m_dy = 1;
        m_wait = 0; m_flash = 0; m_hx = 0; m_hy = 0;
    endtask

    task automatic move_axis(inout int pos, inout int dir, input int speed, input int limit, output bit hit);
        int np;
        np  = pos + dir * speed;
        hit = 0;
        if (np > limit) begin np = limit; dir = -1; hit = 1; end
        else if (np < 0) begin np = 0; dir = 1; hit = 1; end
        pos = np;
    endtask

    task automatic model_tick(input bit sv);
        m_hx = 0; m_hy = 0;
        if (m_flash > 0) m_flash--;
        if (sv) begin
            m_bx = SX; m_by = SY; m_wait = 0; m_dx = -m_dx; m_flash = 0;
        end else if (run) begin
            if (m_wait < SF) m_wait++;
            else begin
                move_axis(m_bx, m_dx, VX, SW - SZ, m_hx);
                move_axis(m_by, m_dy, VY, SH - SZ, m_hy);
            end
        end
        if (m_hx || m_hy) m_flash = 4;
    endtask

    function automatic bit covers(input int px, input int py);
        return (px >= m_bx) && (px < m_bx + SZ) && (py >= m_by) && (py < m_by + SZ);
    endfunction

    function automatic logic [5:0] exp_rgb();
`ifdef BALL_HIT_FLASH_EN
        return (m_flash != 0) ? {~CR, ~CG, ~CB} : {CR, CG, CB};
`else
        return {CR, CG, CB};
`endif
    endfunction

    // One frame tick; returns at the falling edge right after the stepping edge.
    task automatic drive_tick(input bit sv);
        @(negedge clk); frame_tick = 1'b1; serve = sv;
        @(negedge clk); frame_tick = 1'b0; serve = 1'b0;
        model_tick(sv);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0;
        model_reset();
        #23;
        checks++;
        if ({bx, by, en, hit_x, hit_y, r, g, b} !== {CW'(m_bx), CW'(m_by), 1'b0, 1'b0, 1'b0, exp_rgb()}) begin
            failures++;
            $display("FAIL reset: bx=%0d by=%0d en=%0b hx=%0b hy=%0b rgb=%b expected bx=%0d by=%0d en=0 hx=0 hy=0 rgb=%b",
                     bx, by, en, hit_x, hit_y, {r, g, b}, m_bx, m_by, exp_rgb());
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_serve_hold();
        run = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive_tick(1'b0);
            checks++;
            if ({bx, by, hit_x, hit_y} !== {CW'(m_bx), CW'(m_by), m_hx, m_hy}) begin
                failures++;
                $display("FAIL serve_hold tick %0d: bx=%0d by=%0d hx=%0b hy=%0b expected bx=%0d by=%0d hx=%0b hy=%0b",
                         i, bx, by, hit_x, hit_y, m_bx, m_by, m_hx, m_hy);
            end
        end
        checks++;
        if ({bx, by} !== {CW'(SX + VX), CW'(SY + VY)}) begin
            failures++;
            $display("FAIL first_move: bx=%0d by=%0d expected bx=%0d by=%0d", bx, by, SX + VX, SY + VY);
        end
    endtask

    task automatic test_bounce(input int n_ticks);
        for (int i = 0; i < n_ticks; i++) begin
            drive_tick(1'b0);
            checks++;
            if ({bx, by, hit_x, hit_y} !== {CW'(m_bx), CW'(m_by), m_hx, m_hy}) begin
                failures++;
                $display("FAIL bounce tick %0d: bx=%0d by=%0d hx=%0b hy=%0b expected bx=%0d by=%0d hx=%0b hy=%0b",
                         i, bx, by, hit_x, hit_y, m_bx, m_by, m_hx, m_hy);
            end
            @(negedge clk);
            checks++;
            if ({hit_x, hit_y, r, g, b} !== {2'b00, exp_rgb()}) begin
                failures++;
                $display("FAIL hit_pulse_len tick %0d: hx=%0b hy=%0b rgb=%b expected hx=0 hy=0 rgb=%b",
                         i, hit_x, hit_y, {r, g, b}, exp_rgb());
            end
        end
    endtask

    task automatic test_run_low();
        run = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_tick(1'b0);
            checks++;
            if ({bx, by, hit_x, hit_y} !== {CW'(m_bx), CW'(m_by), m_hx, m_hy}) begin
                failures++;
                $display("FAIL run_low tick %0d: bx=%0d by=%0d hx=%0b hy=%0b expected bx=%0d by=%0d hx=%0b hy=%0b",
                         i, bx, by, hit_x, hit_y, m_bx, m_by, m_hx, m_hy);
            end
        end
        run = 1'b1;
    endtask

    task automatic test_serve_with_tick();
        drive_tick(1'b1);
        checks++;
        if ({bx, by, hit_x, hit_y} !== {CW'(SX), CW'(SY), 2'b00}) begin
            failures++;
            $display("FAIL serve_tick: bx=%0d by=%0d hx=%0b hy=%0b expected bx=%0d by=%0d hx=0 hy=0",
                     bx, by, hit_x, hit_y, SX, SY);
        end
        // Hold frames followed by steps reveal the inverted x direction
        for (int i = 0; i < SF + 3; i++) begin
            drive_tick(1'b0);
            checks++;
            if ({bx, by} !== {CW'(m_bx), CW'(m_by)}) begin
                failures++;
                $display("FAIL after_serve tick %0d: bx=%0d by=%0d expected bx=%0d by=%0d", i, bx, by, m_bx, m_by);
            end
        end
    endtask

    task automatic test_scan();
        int  seen = 0;
        bit  prev;
        @(negedge clk);
        y    = CW'(m_by);
        x    = CW'(m_bx - 1);
        prev = covers(int'(x), int'(y));
        for (int i = 0; i <= SZ + 1; i++) begin
            @(negedge clk);
            checks++;
            if (en !== prev) begin
                failures++;
                $display("FAIL scan x=%0d: en=%0b expected %0b", int'(x) - 1 + 0, en, prev);
            end
            if (en === 1'b1) seen++;
            x    = CW'(m_bx + i);
            prev = covers(int'(x), int'(y));
        end
        checks++;
        if (seen != SZ) begin
            failures++;
            $display("FAIL scan_width: en high for %0d cycles expected %0d", seen, SZ);
        end
    endtask

    task automatic test_random(input int n);
        bit sv;
        bit exp_en;
        for (int i = 0; i < n; i++) begin
            run = ($urandom_range(3, 0) != 0);
            sv  = ($urandom_range(15, 0) == 0);
            drive_tick(sv);
            checks++;
            if ({bx, by, hit_x, hit_y} !== {CW'(m_bx), CW'(m_by), m_hx, m_hy}) begin
                failures++;
                $display("FAIL random tick %0d: bx=%0d by=%0d hx=%0b hy=%0b expected bx=%0d by=%0d hx=%0b hy=%0b",
                         i, bx, by, hit_x, hit_y, m_bx, m_by, m_hx, m_hy);
            end
            @(negedge clk);
            checks++;
            if ({hit_x, hit_y, r, g, b} !== {2'b00, exp_rgb()}) begin
                failures++;
                $display("FAIL random_after tick %0d: hx=%0b hy=%0b rgb=%b expected hx=0 hy=0 rgb=%b",
                         i, hit_x, hit_y, {r, g, b}, exp_rgb());
            end
            x = CW'(m_bx + int'($urandom_range(2 * SZ, 0)) - SZ);
            y = CW'(m_by + int'($urandom_range(2 * SZ, 0)) - SZ);
            exp_en = covers(int'(x), int'(y));
            @(negedge clk);
            checks++;
            if (en !== exp_en) begin
                failures++;
                $display("FAIL random_en x=%0d y=%0d: en=%0b expected %0b", x, y, en, exp_en);
            end
        end
        run = 1'b1;
    endtask

    task automatic test_async_reset();
        drive_tick(1'b0);
        drive_tick(1'b0);
        drive_tick(1'b0);
        @(negedge clk);
        x = CW'(m_bx); y = CW'(m_by);
        @(negedge clk);
        checks++;
        if (en !== 1'b1) begin
            failures++;
            $display("FAIL en_before_reset: en=%0b expected 1", en);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({bx, by, en, hit_x, hit_y, r, g, b} !== {CW'(SX), CW'(SY), 1'b0, 1'b0, 1'b0, exp_rgb()}) begin
            failures++;
            $display("FAIL async_reset: bx=%0d by=%0d en=%0b hx=%0b hy=%0b rgb=%b expected bx=%0d by=%0d en=0 hx=0 hy=0 rgb=%b",
                     bx, by, en, hit_x, hit_y, {r, g, b}, SX, SY, exp_rgb());
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        run   = 1'b1;
        // After reset the hold restarts and x moves right again
        for (int i = 0; i < SF + 2; i++) begin
            drive_tick(1'b0);
            checks++;
            if ({bx, by} !== {CW'(m_bx), CW'(m_by)}) begin
                failures++;
                $display("FAIL post_reset tick %0d: bx=%0d by=%0d expected bx=%0d by=%0d", i, bx, by, m_bx, m_by);
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve_hold();
        test_bounce(175);
        test_run_low();
        test_scan();
        test_serve_with_tick();
        test_random(200);
        test_scan();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
